dcm_lock_supervisor: RTL and testbench



---
 rtl/clk_pkg.sv | 25 ++
 rtl/sync2.sv | 25 ++
 rtl/dcm_lock_supervisor.sv | 130 +++++++++++++
 tb/tb_dcm_lock_supervisor.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_pkg.sv
// Shared definitions for the DCM lock supervisor: FSM state encoding,
// default timing constants and a small saturating-increment helper.
package clk_pkg;

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAIL   = 3'd4
    } sup_state_e;

    localparam int DEF_RST_CYCLES    = 8;
    localparam int DEF_LOCK_TIMEOUT  = 65535;
    localparam int DEF_STABLE_CYCLES = 255;
    localparam int DEF_MAX_RETRY     = 4;
    localparam int DEF_CNT_W         = 16;
    localparam int RETRY_W           = 3;

    // The retry counter saturates at 7 rather than wrapping back to zero.
    function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with asynchronous active-low clear, used to bring
// the DCM LOCKED signal into the clk48 domain.
module sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/dcm_lock_supervisor.sv
// Drives the DCM reset, retries until LOCKED is stable for long enough, and
// holds the downstream system reset until the lock has been qualified.
module dcm_lock_supervisor
    import clk_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRY     = DEF_MAX_RETRY,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic       clk48,
    input  logic       rst_n,
    input  logic       dcm_lock,
    input  logic       restart,
    output logic       dcm_rst,
    output logic       sys_rst,
    output logic       clk_ok,
    output logic       fail,
    output logic [2:0] retry_cnt
);

    // Each phase ends on the cycle whose increment would reach its limit.
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    sup_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               dcm_rst_q, sys_rst_q, clk_ok_q, fail_q;
    logic               lock_s;

    sync2 u_lock_sync (
        .clk_i  (clk48),
        .rst_ni (rst_n),
        .d_i    (dcm_lock),
        .q_o    (lock_s)
    );

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        if (restart) begin
            state_d = S_RST;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                S_RST: begin
                    if (cnt_q >= RST_LAST) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                        retry_d = retry_inc(retry_q);
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                // A lock seen on the timeout cycle still counts as a lock.
                S_WAIT: begin
                    if (lock_s) begin
                        state_d = S_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q >= WAIT_LAST) begin
                        state_d = (int'(retry_q) >= MAX_RETRY) ? S_FAIL : S_RST;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end else if (cnt_q >= STABLE_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state_d = S_RST;
                        cnt_d   = '0;
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d = S_RST;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RST;
            cnt_q     <= '0;
            retry_q   <= '0;
            dcm_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            clk_ok_q  <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            dcm_rst_q <= (state_d == S_RST) || (state_d == S_FAIL);
            sys_rst_q <= (state_d != S_RUN);
            clk_ok_q  <= (state_d == S_RUN);
            fail_q    <= (state_d == S_FAIL);
        end
    end

    assign dcm_rst   = dcm_rst_q;
    assign sys_rst   = sys_rst_q;
    assign clk_ok    = clk_ok_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_dcm_lock_supervisor.sv
// Bench for dcm_lock_supervisor: directed scenarios with hand-computed timings,
// then random lock/restart traffic, all compared every cycle with a reference model.
module tb_dcm_lock_supervisor;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRY     = 2;

    localparam int PH_RESETTING   = 0;
    localparam int PH_WAITING     = 1;
    localparam int PH_STABILISING = 2;
    localparam int PH_RUNNING     = 3;
    localparam int PH_FAILED      = 4;

    logic       clk48 = 1'b0;
    logic       rst_n;
    logic       dcm_lock = 1'b0;
    logic       restart = 1'b0;
    logic       dcm_rst, sys_rst, clk_ok, fail;
    logic [2:0] retry_cnt;

    int errors = 0;
    int checks = 0;

    int         mPhase   = PH_RESETTING;
    int         mElapsed = 0;
    int         mTries   = 0;
    logic [1:0] lockDly  = 2'b00;
    bit         modelCheckEn = 1'b0;

    dcm_lock_supervisor #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRY     (MAX_RETRY),
        .CNT_W         (16)
    ) dut (
        .clk48     (clk48),
        .rst_n     (rst_n),
        .dcm_lock  (dcm_lock),
        .restart   (restart),
        .dcm_rst   (dcm_rst),
        .sys_rst   (sys_rst),
        .clk_ok    (clk_ok),
        .fail      (fail),
        .retry_cnt (retry_cnt)
    );

    always #5 clk48 = ~clk48;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic lock, input logic rs);
        dcm_lock = lock;
        restart  = rs;
    endtask

    // which: 0=dcm_rst 1=clk_ok 2=fail 3=sys_rst; cycles counts negedges waited.
    task automatic waitFor(input string name, input int which, input logic level,
                           input int bound, output int cycles);
        logic v;
        cycles = 0;
        do begin
            @(negedge clk48);
            cycles++;
            case (which)
                0:       v = dcm_rst;
                1:       v = clk_ok;
                2:       v = fail;
                default: v = sys_rst;
            endcase
        end while (v !== level && cycles < bound);
        checkOutput({"reach_", name}, 32'(v), 32'(level));
    endtask

    // Phase-and-duration view of the supervisor: LOCKED is seen two edges late.
    always @(posedge clk48 or negedge rst_n) begin : refModel
        int   ph, el, tr;
        logic seen;
        if (!rst_n) begin
            mPhase   <= PH_RESETTING;
            mElapsed <= 0;
            mTries   <= 0;
            lockDly  <= 2'b00;
        end else begin
            seen = lockDly[1];
            ph   = mPhase;
            el   = mElapsed;
            tr   = mTries;
            if (restart) begin
                ph = PH_RESETTING;
                el = 0;
                tr = 0;
            end else if (ph == PH_RESETTING) begin
                el = el + 1;
                if (el >= RST_CYCLES) begin
                    tr = (tr < 7) ? tr + 1 : 7;
                    ph = PH_WAITING;
                    el = 0;
                end
            end else if (ph == PH_WAITING) begin
                el = el + 1;
                if (seen) begin
                    ph = PH_STABILISING;
                    el = 0;
                end else if (el >= LOCK_TIMEOUT) begin
                    ph = (tr >= MAX_RETRY) ? PH_FAILED : PH_RESETTING;
                    el = 0;
                end
            end else if (ph == PH_STABILISING) begin
                if (!seen) begin
                    ph = PH_WAITING;
                    el = 0;
                end else begin
                    el = el + 1;
                    if (el >= STABLE_CYCLES) begin
                        ph = PH_RUNNING;
                        el = 0;
                        tr = 0;
                    end
                end
            end else if (ph == PH_RUNNING) begin
                if (!seen) begin
                    ph = PH_RESETTING;
                    el = 0;
                end
            end
            mPhase   <= ph;
            mElapsed <= el;
            mTries   <= tr;
            lockDly  <= {lockDly[0], dcm_lock};
        end
    end

    always @(negedge clk48) begin
        if (modelCheckEn) begin
            checkOutput("model_dcm_rst", 32'(dcm_rst), 32'(mPhase == PH_RESETTING || mPhase == PH_FAILED));
            checkOutput("model_sys_rst", 32'(sys_rst), 32'(mPhase != PH_RUNNING));
            checkOutput("model_clk_ok", 32'(clk_ok), 32'(mPhase == PH_RUNNING));
            checkOutput("model_fail", 32'(fail), 32'(mPhase == PH_FAILED));
            checkOutput("model_retry_cnt", 32'(retry_cnt), 32'(mTries));
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   k;
        int   pulses;
        int   lowCycles;
        logic prevRst;

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset_dcm_rst", 32'(dcm_rst), 32'd1);
        checkOutput("reset_sys_rst", 32'(sys_rst), 32'd1);
        checkOutput("reset_clk_ok", 32'(clk_ok), 32'd0);
        checkOutput("reset_fail", 32'(fail), 32'd0);
        checkOutput("reset_retry_cnt", 32'(retry_cnt), 32'd0);
        modelCheckEn = 1'b1;
        repeat (2) @(negedge clk48);
        rst_n = 1'b1;

        // Power-up with lock arriving 10 cycles after the DCM leaves reset.
        waitFor("dcm_rst_low", 0, 1'b0, 50, k);
        checkOutput("powerup_rst_width", 32'(k), 32'(RST_CYCLES));
        checkOutput("powerup_retry_before_run", 32'(retry_cnt), 32'd1);
        repeat (10) @(negedge clk48);
        applyStimulus(1'b1, 1'b0);
        waitFor("clk_ok_high", 1, 1'b1, 100, k);
        checkOutput("lock_to_run_cycles", 32'(k), 32'd11);
        checkOutput("run_sys_rst", 32'(sys_rst), 32'd0);
        checkOutput("run_retry_cnt", 32'(retry_cnt), 32'd0);

        // Fresh sequence, then a one-cycle LOCKED glitch partway through qualification.
        applyStimulus(1'b0, 1'b1);
        @(negedge clk48);
        applyStimulus(1'b0, 1'b0);
        waitFor("dcm_rst_low", 0, 1'b0, 50, k);
        checkOutput("restart_rst_width", 32'(k), 32'(RST_CYCLES));
        applyStimulus(1'b1, 1'b0);
        repeat (6) @(negedge clk48);
        applyStimulus(1'b0, 1'b0);
        @(negedge clk48);
        applyStimulus(1'b1, 1'b0);
        waitFor("clk_ok_high", 1, 1'b1, 100, k);
        checkOutput("glitch_restore_to_run", 32'(k), 32'd11);

        // Lock loss while running, then automatic recovery.
        applyStimulus(1'b0, 1'b0);
        @(negedge clk48);
        applyStimulus(1'b1, 1'b0);
        waitFor("clk_ok_low", 1, 1'b0, 20, k);
        checkOutput("drop_to_clk_ok_low", 32'(k + 1), 32'd3);
        checkOutput("drop_sys_rst", 32'(sys_rst), 32'd1);
        waitFor("dcm_rst_low", 0, 1'b0, 50, k);
        checkOutput("recover_rst_width", 32'(k), 32'(RST_CYCLES));
        waitFor("clk_ok_high", 1, 1'b1, 100, k);
        checkOutput("recover_to_run", 32'(k), 32'd9);

        // LOCKED never asserts: two timed pulses then the sticky failure.
        applyStimulus(1'b0, 1'b1);
        @(negedge clk48);
        applyStimulus(1'b0, 1'b0);
        pulses = 0;
        lowCycles = 0;
        prevRst = 1'b0;
        k = 0;
        while (fail !== 1'b1 && k < 200) begin
            if (dcm_rst === 1'b1 && prevRst === 1'b0) pulses++;
            if (dcm_rst === 1'b0) lowCycles++;
            prevRst = dcm_rst;
            @(negedge clk48);
            k++;
        end
        checkOutput("nolock_fail_set", 32'(fail), 32'd1);
        checkOutput("nolock_pulses", 32'(pulses), 32'd2);
        checkOutput("nolock_low_cycles", 32'(lowCycles), 32'(2 * LOCK_TIMEOUT));
        checkOutput("nolock_retry_cnt", 32'(retry_cnt), 32'(MAX_RETRY));
        repeat (5) @(negedge clk48);
        checkOutput("fail_sticky", 32'(fail), 32'd1);
        checkOutput("fail_dcm_rst", 32'(dcm_rst), 32'd1);
        checkOutput("fail_sys_rst", 32'(sys_rst), 32'd1);

        // Restart out of the failed state.
        applyStimulus(1'b0, 1'b1);
        @(negedge clk48);
        applyStimulus(1'b0, 1'b0);
        checkOutput("restart_fail_clear", 32'(fail), 32'd0);
        checkOutput("restart_retry_clear", 32'(retry_cnt), 32'd0);
        checkOutput("restart_dcm_rst", 32'(dcm_rst), 32'd1);
        waitFor("dcm_rst_low", 0, 1'b0, 50, k);
        checkOutput("restart_pulse_width", 32'(k), 32'(RST_CYCLES));

        // Restart landing on the cycle of the final timeout must win.
        waitFor("dcm_rst_high", 0, 1'b1, 50, k);
        checkOutput("wait_timeout_len", 32'(k), 32'(LOCK_TIMEOUT));
        waitFor("dcm_rst_low", 0, 1'b0, 50, k);
        checkOutput("second_retry_cnt", 32'(retry_cnt), 32'd2);
        repeat (LOCK_TIMEOUT - 1) @(negedge clk48);
        applyStimulus(1'b0, 1'b1);
        @(negedge clk48);
        applyStimulus(1'b1, 1'b0);
        checkOutput("restart_beats_timeout", 32'(fail), 32'd0);
        checkOutput("restart_beats_retry", 32'(retry_cnt), 32'd0);
        checkOutput("restart_beats_dcm_rst", 32'(dcm_rst), 32'd1);

        // Asynchronous reset while qualifying lock, between clock edges.
        waitFor("dcm_rst_low", 0, 1'b0, 50, k);
        repeat (4) @(negedge clk48);
        checkOutput("stable_dcm_rst", 32'(dcm_rst), 32'd0);
        checkOutput("stable_sys_rst", 32'(sys_rst), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_dcm_rst", 32'(dcm_rst), 32'd1);
        checkOutput("async_sys_rst", 32'(sys_rst), 32'd1);
        checkOutput("async_clk_ok", 32'(clk_ok), 32'd0);
        @(negedge clk48);
        rst_n = 1'b1;

        // Random LOCKED behaviour with occasional restarts and board resets.
        for (int seg = 0; seg < 150; seg++) begin
            logic lvl;
            int   len;
            lvl = ($urandom_range(0, 99) < 70);
            len = lvl ? $urandom_range(1, 60) : $urandom_range(1, 30);
            if ($urandom_range(0, 39) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk48);
                rst_n = 1'b1;
            end
            for (int c = 0; c < len; c++) begin
                applyStimulus(lvl, ($urandom_range(0, 149) == 0));
                @(negedge clk48);
            end
        end
        applyStimulus(1'b0, 1'b0);
        repeat (2) @(negedge clk48);
        modelCheckEn = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
